// File: rtl/time_matrix_clock.sv
// time_matrix_clock: time-of-day core (hours/minutes/seconds) driven either by
// an internal prescaler or by a disciplining PPS input with holdover, with
// front-panel set buttons and a 4x6 LED matrix scanner that shows the time in
// binary or BCD.
module time_matrix_clock #(
  parameter int TICKS_PER_SEC = 100,
  parameter int SCAN_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pps,
  input  logic       pps_en,
  input  logic       set_hour,
  input  logic       set_min,
  input  logic       bcd,
  input  logic [4:0] hours_init,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       day_roll,
  output logic       pps_locked,
  output logic [3:0] rows,
  output logic [5:0] cols
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int HW = $clog2(2 * TICKS_PER_SEC);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(2 * TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);

  // PPS synchroniser and edge history
  logic pps_meta_reg, pps_sync_reg, pps_prev_reg;

  // second-source state
  logic [PW-1:0] presc_reg, presc_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          locked_reg, locked_next;
  logic          pps_edge, pps_tick, presc_wrap, hold_expired, lock_drop, sec_event;

  // time-of-day state
  logic [4:0] hours_reg, hours_next;
  logic [5:0] minutes_reg, minutes_next;
  logic [5:0] seconds_reg, seconds_next;
  logic       sec_tick_reg, sec_tick_next;
  logic       day_roll_reg, day_roll_next;
  logic       count_tick, sec_last, min_last, hour_last, hour_carry;

  // matrix scanner state
  logic [SW-1:0]   scan_phase_reg, scan_phase_next;
  logic [1:0]      scan_row_reg, scan_row_next;
  logic [3:0]      rows_reg, rows_next;
  logic [5:0]      cols_reg, cols_next;
  logic [5:0][3:0] digit;
  logic [5:0]      bcd_cols;
  logic [5:0]      bin_cols;

  // Two-flop synchroniser for the asynchronous PPS, plus the previous sample for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      pps_meta_reg <= 1'b0;
      pps_sync_reg <= 1'b0;
      pps_prev_reg <= 1'b0;
    end else begin
      pps_meta_reg <= pps;
      pps_sync_reg <= pps_meta_reg;
      pps_prev_reg <= pps_sync_reg;
    end
  end

  // Choose the second source: PPS edges while locked, prescaler wraps otherwise
  always_comb begin
    pps_edge     = pps_sync_reg & ~pps_prev_reg;
    pps_tick     = pps_edge & pps_en;
    presc_wrap   = (presc_reg == PRESC_LAST);
    hold_expired = (hold_reg == HOLD_LAST);
    // a fresh enabled edge keeps the lock even if holdover just ran out
    lock_drop    = locked_reg & ~pps_tick & (~pps_en | hold_expired);
    // OR-ing the two sources keeps a coincident wrap and edge to a single tick
    sec_event    = pps_tick | (presc_wrap & ~locked_reg);

    presc_next = presc_wrap ? '0 : presc_reg + PW'(1);
    if (pps_tick || lock_drop || set_min) begin
      presc_next = '0;
    end

    locked_next = locked_reg;
    if (pps_tick) begin
      locked_next = 1'b1;
    end else if (lock_drop) begin
      locked_next = 1'b0;
    end

    // holdover only runs while locked and restarts on every synchronised edge
    hold_next = (pps_edge || !locked_reg || lock_drop) ? '0 : hold_reg + HW'(1);
  end

  // Prescaler, holdover counter and lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg  <= '0;
      hold_reg   <= '0;
      locked_reg <= 1'b0;
    end else begin
      presc_reg  <= presc_next;
      hold_reg   <= hold_next;
      locked_reg <= locked_next;
    end
  end

  // Time-of-day next state: counting carries, set buttons and their priorities
  always_comb begin
    count_tick = sec_event & ~set_min;
    sec_last   = (seconds_reg == 6'd59);
    min_last   = (minutes_reg == 6'd59);
    hour_last  = (hours_reg == 5'd23);
    hour_carry = count_tick & sec_last & min_last;

    seconds_next = seconds_reg;
    minutes_next = minutes_reg;
    hours_next   = hours_reg;

    if (set_min) begin
      // manual minute step discards any second tick and never carries into hours
      seconds_next = 6'd0;
      minutes_next = min_last ? 6'd0 : minutes_reg + 6'd1;
    end else if (count_tick) begin
      seconds_next = sec_last ? 6'd0 : seconds_reg + 6'd1;
      if (sec_last) begin
        minutes_next = min_last ? 6'd0 : minutes_reg + 6'd1;
      end
    end

    // a button press and a counting carry in the same cycle advance hours once
    if (set_hour || hour_carry) begin
      hours_next = hour_last ? 5'd0 : hours_reg + 5'd1;
    end

    sec_tick_next = count_tick;
    day_roll_next = hour_carry & hour_last;
  end

  // Time registers and their event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      hours_reg    <= (hours_init >= 5'd24) ? 5'd0 : hours_init;
      minutes_reg  <= 6'd0;
      seconds_reg  <= 6'd0;
      sec_tick_reg <= 1'b0;
      day_roll_reg <= 1'b0;
    end else begin
      hours_reg    <= hours_next;
      minutes_reg  <= minutes_next;
      seconds_reg  <= seconds_next;
      sec_tick_reg <= sec_tick_next;
      day_roll_reg <= day_roll_next;
    end
  end

  // Decimal digits in column order: s units, s tens, m units, m tens, h units, h tens
  always_comb begin
    digit[0] = 4'(seconds_reg % 6'd10);
    digit[1] = 4'(seconds_reg / 6'd10);
    digit[2] = 4'(minutes_reg % 6'd10);
    digit[3] = 4'(minutes_reg / 6'd10);
    digit[4] = 4'(hours_reg % 5'd10);
    digit[5] = 4'(hours_reg / 5'd10);
  end

  // In BCD mode each column is one digit and the scanned row picks its bit
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_bcd_col
      assign bcd_cols[gi] = digit[gi][scan_row_reg];
    end
  endgenerate

  // Binary mode: one time field per row, bit j on column j
  always_comb begin
    bin_cols = 6'd0;
    unique case (scan_row_reg)
      2'd0:    bin_cols = seconds_reg;
      2'd1:    bin_cols = minutes_reg;
      2'd2:    bin_cols = {1'b0, hours_reg};
      default: bin_cols = 6'd0;
    endcase
  end

  // Scan sequencing and the registered matrix drive; first cycle of each slot is blank
  always_comb begin
    scan_phase_next = scan_phase_reg + SW'(1);
    scan_row_next   = scan_row_reg;
    if (scan_phase_reg == SCAN_LAST) begin
      scan_phase_next = '0;
      scan_row_next   = scan_row_reg + 2'd1;
    end

    if (scan_phase_reg == '0) begin
      rows_next = 4'b1111;
      cols_next = 6'd0;
    end else begin
      rows_next = ~(4'b0001 << scan_row_reg);
      cols_next = bcd ? bcd_cols : bin_cols;
    end
  end

  // Scanner counters and matrix output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_phase_reg <= '0;
      scan_row_reg   <= 2'd0;
      rows_reg       <= 4'b1111;
      cols_reg       <= 6'd0;
    end else begin
      scan_phase_reg <= scan_phase_next;
      scan_row_reg   <= scan_row_next;
      rows_reg       <= rows_next;
      cols_reg       <= cols_next;
    end
  end

  assign hours      = hours_reg;
  assign minutes    = minutes_reg;
  assign seconds    = seconds_reg;
  assign sec_tick   = sec_tick_reg;
  assign day_roll   = day_roll_reg;
  assign pps_locked = locked_reg;
  assign rows       = rows_reg;
  assign cols       = cols_reg;

endmodule

// File: tb/tb_time_matrix_clock.sv
// Self-checking bench for time_matrix_clock. The reference model keeps time as
// seconds-of-day and derives second ticks, lock state and display contents from
// cycle-number arithmetic.
module tb_time_matrix_clock;

  localparam int T = 4;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pps = 1'b0;
  logic       pps_en = 1'b0;
  logic       set_hour = 1'b0;
  logic       set_min = 1'b0;
  logic       bcd = 1'b0;
  logic [4:0] hours_init = 5'd0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       day_roll;
  logic       pps_locked;
  logic [3:0] rows;
  logic [5:0] cols;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  time_matrix_clock #(.TICKS_PER_SEC(T), .SCAN_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .pps(pps), .pps_en(pps_en), .set_hour(set_hour),
    .set_min(set_min), .bcd(bcd), .hours_init(hours_init), .hours(hours),
    .minutes(minutes), .seconds(seconds), .sec_tick(sec_tick), .day_roll(day_roll),
    .pps_locked(pps_locked), .rows(rows), .cols(cols)
  );

  // ---------------- reference model ----------------
  int         cyc;        // cycles since reset release
  int         tod;        // seconds of day
  int         p0;         // cycle at which the internal second count last restarted
  int         last_edge;  // cycle of the most recent synchronised PPS edge
  bit         m_locked;
  bit         e_tick, e_roll;
  logic [3:0] e_rows;
  logic [5:0] e_cols;
  bit         pps_log [0:8191];

  function automatic logic [5:0] disp_cols(input int t, input int row, input bit b);
    int h, m, s;
    int d [6];
    logic [5:0] c;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    c = '0;
    if (b) begin
      d[0] = s % 10; d[1] = s / 10; d[2] = m % 10;
      d[3] = m / 10; d[4] = h % 10; d[5] = h / 10;
      for (int k = 0; k < 6; k++) c[k] = ((d[k] >> row) & 1) != 0;
    end else begin
      case (row)
        0: c = 6'(s);
        1: c = 6'(m);
        2: c = 6'(h);
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // pps driven in cycle c is seen as an edge in cycle c+2
  function automatic bit edge_now();
    bit cur, old;
    cur = (cyc >= 2) ? pps_log[cyc-2] : 1'b0;
    old = (cyc >= 3) ? pps_log[cyc-3] : 1'b0;
    return cur && !old;
  endfunction

  function automatic bit tick_now();
    return (edge_now() && pps_en) || (!m_locked && ((cyc - p0) % T == T - 1));
  endfunction

  function automatic logic [29:0] exp_vec();
    return {5'(tod / 3600), 6'((tod / 60) % 60), 6'(tod % 60), e_tick, e_roll, m_locked, e_rows, e_cols};
  endfunction

  function automatic logic [29:0] obs_vec();
    return {hours, minutes, seconds, sec_tick, day_roll, pps_locked, rows, cols};
  endfunction

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic step();
    int h, m, s, row;
    bit edge_seen, ptick, cnt, carry;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    edge_seen = edge_now();
    ptick = edge_seen && pps_en;
    cnt   = tick_now() && !set_min;
    carry = cnt && s == 59 && m == 59;
    row   = (cyc / S) % 4;
    if (cyc % S == 0) begin
      e_rows = 4'b1111;
      e_cols = '0;
    end else begin
      e_rows = ~(4'b0001 << row);
      e_cols = disp_cols(tod, row, bcd);
    end
    e_tick = cnt;
    e_roll = carry && h == 23;
    if (set_min) begin
      s = 0; m = (m + 1) % 60;
    end else if (cnt) begin
      if (s == 59) begin s = 0; m = (m + 1) % 60; end
      else s = s + 1;
    end
    if (set_hour || carry) h = (h + 1) % 24;
    tod = h * 3600 + m * 60 + s;
    if (ptick) begin
      m_locked = 1; p0 = cyc + 1;
    end else if (m_locked && (!pps_en || cyc - last_edge >= 2 * T)) begin
      m_locked = 0; p0 = cyc + 1;
    end
    if (edge_seen) last_edge = cyc;
    if (set_min) p0 = cyc + 1;
    if (cyc < 8192) pps_log[cyc] = pps;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] init);
    rst = 1; hours_init = init; pps = 0; pps_en = 0; bcd = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0; set_min = 0; set_hour = 0;
    cyc = 0; tod = ((init >= 24) ? 0 : int'(init)) * 3600; p0 = 0; last_edge = -1000;
    m_locked = 0; e_tick = 0; e_roll = 0; e_rows = 4'b1111; e_cols = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(5'd25);
    total++;
    if (hours !== 5'd0 || rows !== 4'b1111 || cols !== 6'd0) begin
      bad++; $display("FAIL reset25 got h=%0d rows=%b cols=%b want h=0 rows=1111 cols=000000", hours, rows, cols);
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (cyc == 2) begin
        total++;
        if (rows !== 4'b1110) begin bad++; $display("FAIL first_row got=%b want=1110", rows); end
      end
      step();
    end
    // reset asserted together with button presses still wins
    set_min = 1; set_hour = 1;
    do_reset(5'd13);
    total++;
    if ({hours, minutes, seconds} !== {5'd13, 6'd0, 6'd0} || sec_tick !== 1'b0) begin
      bad++; $display("FAIL reset13 got %0d:%0d:%0d tick=%b want 13:0:0 tick=0", hours, minutes, seconds, sec_tick);
    end
  endtask

  task automatic test_rollover();
    int n, ticks, rolls;
    do_reset(5'd23);
    for (int i = 0; i < 59; i++) begin
      set_min = 1; step(); set_min = 0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL set_min_seq cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n = 0;
    while (!(e_tick && tod % 60 == 58) && n < 400) begin
      step(); n++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL run_to_58 cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if (seconds !== 6'd58 || minutes !== 6'd59 || hours !== 5'd23) begin
      bad++; $display("FAIL reach_235958 got %0d:%0d:%0d want 23:59:58", hours, minutes, seconds);
    end
    ticks = 0; rolls = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      ticks += int'(sec_tick); rolls += int'(day_roll);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL rollover cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({hours, minutes, seconds} !== 17'd0) begin
      bad++; $display("FAIL midnight got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
    end
    total++;
    if (rolls != 1 || ticks != 2) begin
      bad++; $display("FAIL pulse_count got rolls=%0d ticks=%0d want rolls=1 ticks=2", rolls, ticks);
    end
  endtask

  task automatic test_pps_lock();
    do_reset(5'd7);
    pps_en = 1;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 6; k++) begin
        pps = (k < 2);
        step();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL pps_periodic cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
        end
      end
    end
    total++;
    if (pps_locked !== 1'b1) begin bad++; $display("FAIL locked got=%b want=1", pps_locked); end
    pps = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL holdover cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if (pps_locked !== 1'b0) begin bad++; $display("FAIL unlocked got=%b want=0", pps_locked); end
    // relock, then withdraw pps_en
    for (int k = 0; k < 12; k++) begin
      pps = (k % 6 < 2);
      if (k == 9) pps_en = 0;
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL pps_en_drop cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    pps = 0;
  endtask

  task automatic test_set_collision();
    int n;
    do_reset(5'd12);
    for (int i = 0; i < 34; i++) begin set_min = 1; step(); set_min = 0; end
    n = 0;
    while (!(tod % 60 == 59 && tick_now()) && n < 400) begin
      step(); n++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL run_to_59 cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    set_min = 1; step(); set_min = 0;
    total++;
    if ({hours, minutes, seconds} !== {5'd12, 6'd35, 6'd0} || sec_tick !== 1'b0) begin
      bad++; $display("FAIL set_min_collide got %0d:%0d:%0d tick=%b want 12:35:0 tick=0", hours, minutes, seconds, sec_tick);
    end
    for (int i = 0; i < 11; i++) begin
      set_hour = 1; step(); set_hour = 0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL set_hour_seq cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    set_hour = 1; step(); set_hour = 0;
    total++;
    if (hours !== 5'd0 || minutes !== 6'd35 || day_roll !== 1'b0) begin
      bad++; $display("FAIL set_hour_wrap got h=%0d m=%0d roll=%b want h=0 m=35 roll=0", hours, minutes, day_roll);
    end
  endtask

  task automatic test_display();
    int n;
    do_reset(5'd12);
    for (int i = 0; i < 34; i++) begin set_min = 1; step(); set_min = 0; end
    n = 0;
    while (!(e_tick && tod % 60 == 56) && n < 400) begin step(); n++; end
    total++;
    if (seconds !== 6'd56 || minutes !== 6'd34 || hours !== 5'd12) begin
      bad++; $display("FAIL reach_123456 got %0d:%0d:%0d want 12:34:56", hours, minutes, seconds);
    end
    for (int i = 0; i < 90; i++) begin
      bcd = (i < 30) ? 1'b1 : (i < 60) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
      total++;
      if (obs_vec() !== exp_vec() || $countones(~rows) > 1) begin
        bad++; $display("FAIL display cyc=%0d bcd=%b got=%h want=%h", cyc, bcd, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int gap;
    do_reset(5'($urandom_range(0, 31)));
    gap = 3;
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 0) pps_en = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        pps = ~pps;
        gap = pps ? $urandom_range(0, 2) : $urandom_range(1, 9);
      end else begin
        gap--;
      end
      set_min  = ($urandom_range(0, 39) == 0);
      set_hour = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) bcd = ~bcd;
      step();
      set_min = 0; set_hour = 0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    pps = 0;
  endtask

  task automatic test_back_to_back();
    do_reset(5'd20);
    for (int i = 0; i < 30; i++) begin
      set_hour = 1; set_min = (i % 2 == 0);
      step();
      set_hour = 0; set_min = 0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_pps_lock();
    test_set_collision();
    test_display();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
